// File: rtl/lmdpl_nl_seq.sv
// Sequencer for one LMDPL masked non-linear gate: builds the mask-dependent table,
// drives dual-rail inputs with precharge discipline. Optional check: LMDPL_ERR_CHECK_EN.
module lmdpl_nl_seq #(
   parameter int EVAL_CYCLES = 2,
   parameter int PRE_CYCLES  = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [3:0] req_func,
   input  logic       req_a_m,
   input  logic       req_b_m,
   input  logic       req_ma,
   input  logic       req_mb,
   input  logic       req_mq,
   output logic [7:0] t,
   output logic       a_m,
   output logic       a_m_bar,
   output logic       b_m,
   output logic       b_m_bar,
   input  logic       q_m,
   input  logic       q_m_bar,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic       rsp_q_m,
   output logic       rsp_err
);

   localparam int MAX_CYCLES = (EVAL_CYCLES > PRE_CYCLES) ? EVAL_CYCLES : PRE_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
   localparam logic [CNT_W-1:0] EVAL_LOAD = CNT_W'(EVAL_CYCLES - 1);
   localparam logic [CNT_W-1:0] PRE_LOAD  = CNT_W'(PRE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   typedef enum logic [2:0] {
      ST_INIT,
      ST_IDLE,
      ST_TABLE,
      ST_EVAL,
      ST_PRE,
      ST_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             a_q, a_d;
   logic             b_q, b_d;
   logic [7:0]       t_q, t_d;
   logic             a_m_q, a_m_d;
   logic             a_m_bar_q, a_m_bar_d;
   logic             b_m_q, b_m_d;
   logic             b_m_bar_q, b_m_bar_d;
   logic             req_ready_q, req_ready_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic             rsp_q_m_q, rsp_q_m_d;

   // Entry i = {ib, ia}: upper half carries f(unmasked)^mq, lower half its complement.
   function automatic logic [7:0] build_table(input logic [3:0] func, input logic ma,
                                              input logic mb, input logic mq);
      logic [7:0] tbl;
      logic [1:0] sel;
      logic [1:0] idx;
      logic       v;
      tbl = '0;
      for (int i = 0; i < 4; i++) begin
         sel        = 2'(i);
         idx        = {sel[1] ^ mb, sel[0] ^ ma};
         v          = func[idx] ^ mq;
         tbl[4 + i] = v;
         tbl[i]     = ~v;
      end
      return tbl;
   endfunction

`ifdef LMDPL_ERR_CHECK_EN
   logic rsp_err_q, rsp_err_d;
`else
   logic unused_q_m_bar;
   assign unused_q_m_bar = q_m_bar;
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      a_d         = a_q;
      b_d         = b_q;
      t_d         = t_q;
      a_m_d       = a_m_q;
      a_m_bar_d   = a_m_bar_q;
      b_m_d       = b_m_q;
      b_m_bar_d   = b_m_bar_q;
      req_ready_d = req_ready_q;
      rsp_valid_d = rsp_valid_q;
      rsp_q_m_d   = rsp_q_m_q;
`ifdef LMDPL_ERR_CHECK_EN
      rsp_err_d   = rsp_err_q;
`endif

      case (state_q)
         ST_INIT: begin
            if (cnt_q == '0) begin
               state_d     = ST_IDLE;
               cnt_d       = '0;
               req_ready_d = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end

         ST_IDLE: begin
            if (req_valid && req_ready_q) begin
               state_d     = ST_TABLE;
               cnt_d       = '0;
               req_ready_d = 1'b0;
               a_d         = req_a_m;
               b_d         = req_b_m;
               t_d         = build_table(req_func, req_ma, req_mb, req_mq);
`ifdef LMDPL_ERR_CHECK_EN
               rsp_err_d   = 1'b0;
`endif
            end
         end

         // Rails only rise once the table has settled for a full cycle.
         ST_TABLE: begin
            state_d   = ST_EVAL;
            cnt_d     = EVAL_LOAD;
            a_m_d     = a_q;
            a_m_bar_d = ~a_q;
            b_m_d     = b_q;
            b_m_bar_d = ~b_q;
         end

         ST_EVAL: begin
            if (cnt_q == '0) begin
               state_d   = ST_PRE;
               cnt_d     = PRE_LOAD;
               t_d       = '0;
               a_m_d     = 1'b0;
               a_m_bar_d = 1'b0;
               b_m_d     = 1'b0;
               b_m_bar_d = 1'b0;
               rsp_q_m_d = q_m;
`ifdef LMDPL_ERR_CHECK_EN
               rsp_err_d = rsp_err_q | (q_m == q_m_bar);
`endif
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end

         ST_PRE: begin
            if (cnt_q == '0) begin
               state_d     = ST_DONE;
               cnt_d       = '0;
               rsp_valid_d = 1'b1;
`ifdef LMDPL_ERR_CHECK_EN
               rsp_err_d   = rsp_err_q | (q_m | q_m_bar);
`endif
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end

         ST_DONE: begin
            if (rsp_ready) begin
               state_d     = ST_IDLE;
               cnt_d       = '0;
               rsp_valid_d = 1'b0;
               req_ready_d = 1'b1;
            end
         end

         default: begin
            state_d     = ST_INIT;
            cnt_d       = PRE_LOAD;
            t_d         = '0;
            a_m_d       = 1'b0;
            a_m_bar_d   = 1'b0;
            b_m_d       = 1'b0;
            b_m_bar_d   = 1'b0;
            req_ready_d = 1'b0;
            rsp_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_INIT;
         cnt_q       <= PRE_LOAD;
         a_q         <= 1'b0;
         b_q         <= 1'b0;
         t_q         <= '0;
         a_m_q       <= 1'b0;
         a_m_bar_q   <= 1'b0;
         b_m_q       <= 1'b0;
         b_m_bar_q   <= 1'b0;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_q_m_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         a_q         <= a_d;
         b_q         <= b_d;
         t_q         <= t_d;
         a_m_q       <= a_m_d;
         a_m_bar_q   <= a_m_bar_d;
         b_m_q       <= b_m_d;
         b_m_bar_q   <= b_m_bar_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_q_m_q   <= rsp_q_m_d;
      end
   end

`ifdef LMDPL_ERR_CHECK_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rsp_err_q <= 1'b0;
      end else begin
         rsp_err_q <= rsp_err_d;
      end
   end

   assign rsp_err = rsp_err_q;
`else
   assign rsp_err = 1'b0;
`endif

   assign req_ready = req_ready_q;
   assign t         = t_q;
   assign a_m       = a_m_q;
   assign a_m_bar   = a_m_bar_q;
   assign b_m       = b_m_q;
   assign b_m_bar   = b_m_bar_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_q_m   = rsp_q_m_q;

endmodule

// File: tb/tb_lmdpl_nl_seq.sv
// Directed bench for lmdpl_nl_seq with a behavioural LMDPL gate model on q_m/q_m_bar.
module tb_lmdpl_nl_seq;

   localparam int EVAL_CYCLES = 2;
   localparam int PRE_CYCLES  = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req_valid;
   logic       req_ready;
   logic [3:0] req_func;
   logic       req_a_m, req_b_m, req_ma, req_mb, req_mq;
   logic [7:0] t;
   logic       a_m, a_m_bar, b_m, b_m_bar;
   logic       q_m, q_m_bar;
   logic       rsp_valid, rsp_ready, rsp_q_m, rsp_err;

   logic       force_q, force_qb;
   logic       gate_q, gate_qb;

   int nChecks = 0;
   int nFail   = 0;

   typedef struct {
      logic [3:0] func;
      logic       am, bm, ma, mb, mq;
      logic [7:0] expT;
      logic       expQ;
   } vec_t;

   vec_t vecs[6];

   always #5 clk = ~clk;

   lmdpl_nl_seq #(.EVAL_CYCLES(EVAL_CYCLES), .PRE_CYCLES(PRE_CYCLES)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_func(req_func),
      .req_a_m(req_a_m), .req_b_m(req_b_m), .req_ma(req_ma), .req_mb(req_mb), .req_mq(req_mq),
      .t(t), .a_m(a_m), .a_m_bar(a_m_bar), .b_m(b_m), .b_m_bar(b_m_bar),
      .q_m(q_m), .q_m_bar(q_m_bar),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_q_m(rsp_q_m), .rsp_err(rsp_err)
   );

   // Gate cell: the selected entry pair drives the outputs; precharged rails give 0/0.
   always_comb begin
      gate_q  = 1'b0;
      gate_qb = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (((i % 2 == 1) ? a_m : a_m_bar) && ((i / 2 == 1) ? b_m : b_m_bar)) begin
            gate_q  = gate_q | t[4 + i];
            gate_qb = gate_qb | t[i];
         end
      end
   end

   assign q_m     = force_q  ? 1'b1 : gate_q;
   assign q_m_bar = force_qb ? 1'b1 : gate_qb;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nFail++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   function automatic logic [7:0] modelTable(input logic [3:0] f, input logic ma, input logic mb, input logic mq);
      logic [7:0] r;
      int         ua, ub;
      logic       fv;
      for (int j = 0; j < 8; j++) begin
         ua   = (j % 2) ^ int'(ma);
         ub   = ((j / 2) % 2) ^ int'(mb);
         fv   = f[ub * 2 + ua] ^ mq;
         r[j] = (j >= 4) ? fv : ~fv;
      end
      return r;
   endfunction

   // One full operation with cycle-by-cycle checks from accept through the handshake.
   task automatic applyStimulus(input logic [3:0] f, input logic am, input logic bm,
                                input logic ma, input logic mb, input logic mq,
                                input logic [7:0] expT, input logic expQ, input logic expErr,
                                input int bpCycles, input int forceMode);
      int waited;
      rsp_ready = (bpCycles == 0);
      waited = 0;
      while (!req_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!req_ready) begin
         checkOutput("req_ready_timeout", 32'(req_ready), 32'd1);
         return;
      end
      req_valid = 1'b1;
      req_func  = f;
      req_a_m   = am;
      req_b_m   = bm;
      req_ma    = ma;
      req_mb    = mb;
      req_mq    = mq;
      @(posedge clk);
      @(negedge clk);
      checkOutput("table_t", 32'(t), 32'(expT));
      checkOutput("table_rails", 32'({a_m, a_m_bar, b_m, b_m_bar}), 32'd0);
      checkOutput("table_req_ready", 32'(req_ready), 32'd0);
      checkOutput("table_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("table_rsp_err", 32'(rsp_err), 32'd0);
      // Garbage while busy must be neither accepted nor latched.
      req_func  = 4'($urandom);
      req_a_m   = 1'($urandom);
      req_b_m   = 1'($urandom);
      req_ma    = 1'($urandom);
      req_mb    = 1'($urandom);
      req_mq    = 1'($urandom);
      for (int k = 0; k < EVAL_CYCLES; k++) begin
         @(negedge clk);
         checkOutput("eval_t", 32'(t), 32'(expT));
         checkOutput("eval_rails", 32'({a_m, a_m_bar, b_m, b_m_bar}), 32'({am, ~am, bm, ~bm}));
         checkOutput("eval_rsp_valid", 32'(rsp_valid), 32'd0);
         if (k == 0 && forceMode == 1) begin
            force_q  = 1'b1;
            force_qb = 1'b1;
         end
      end
      for (int k = 0; k < PRE_CYCLES; k++) begin
         @(negedge clk);
         force_q  = 1'b0;
         force_qb = 1'b0;
         checkOutput("pre_t", 32'(t), 32'd0);
         checkOutput("pre_rails", 32'({a_m, a_m_bar, b_m, b_m_bar}), 32'd0);
         checkOutput("pre_rsp_valid", 32'(rsp_valid), 32'd0);
         if (k == PRE_CYCLES - 1 && forceMode == 2) force_q = 1'b1;
      end
      @(negedge clk);
      force_q   = 1'b0;
      force_qb  = 1'b0;
      req_valid = 1'b0;
      checkOutput("done_rsp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("done_rsp_q_m", 32'(rsp_q_m), 32'(expQ));
      checkOutput("done_rsp_err", 32'(rsp_err), 32'(expErr));
      checkOutput("done_req_ready", 32'(req_ready), 32'd0);
      checkOutput("done_drive", 32'({t, a_m, a_m_bar, b_m, b_m_bar}), 32'd0);
      for (int k = 0; k < bpCycles; k++) begin
         @(negedge clk);
         checkOutput("bp_rsp_valid", 32'(rsp_valid), 32'd1);
         checkOutput("bp_rsp_q_m", 32'(rsp_q_m), 32'(expQ));
         checkOutput("bp_req_ready", 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      checkOutput("post_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("post_req_ready", 32'(req_ready), 32'd1);
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: time limit reached, nChecks=%0d", nChecks);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic errExp;
      logic [3:0] f;
      logic [4:0] c;
      logic expQ;
`ifdef LMDPL_ERR_CHECK_EN
      errExp = 1'b1;
`else
      errExp = 1'b0;
`endif
      //                 func     am    bm    ma    mb    mq    t      q
      vecs[0] = '{4'b1000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'hB4, 1'b0};
      vecs[1] = '{4'b0110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h69, 1'b1};
      vecs[2] = '{4'b1110, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h4B, 1'b0};
      vecs[3] = '{4'b0111, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hE1, 1'b0};
      vecs[4] = '{4'b1111, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h0F, 1'b0};
      vecs[5] = '{4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hD2, 1'b0};

      rst_n     = 1'b0;
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      force_q   = 1'b0;
      force_qb  = 1'b0;
      req_func  = 4'h0;
      req_a_m   = 1'b0;
      req_b_m   = 1'b0;
      req_ma    = 1'b0;
      req_mb    = 1'b0;
      req_mq    = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
      checkOutput("reset_drive", 32'({t, a_m, a_m_bar, b_m, b_m_bar}), 32'd0);
      checkOutput("reset_rsp", 32'({rsp_valid, rsp_q_m, rsp_err}), 32'd0);

      // Release with a request already pending; it must wait for INIT to finish.
      req_valid = 1'b1;
      req_func  = vecs[0].func;
      rst_n     = 1'b1;
      for (int k = 0; k < PRE_CYCLES - 1; k++) begin
         @(negedge clk);
         checkOutput("init_req_ready", 32'(req_ready), 32'd0);
         checkOutput("init_drive", 32'({t, a_m, a_m_bar, b_m, b_m_bar}), 32'd0);
      end
      @(negedge clk);
      checkOutput("init_done_req_ready", 32'(req_ready), 32'd1);
      checkOutput("init_done_drive", 32'({t, a_m, a_m_bar, b_m, b_m_bar}), 32'd0);

      foreach (vecs[i])
         applyStimulus(vecs[i].func, vecs[i].am, vecs[i].bm, vecs[i].ma, vecs[i].mb, vecs[i].mq,
                       vecs[i].expT, vecs[i].expQ, 1'b0, 0, 0);

      $display("[TB] backpressure");
      applyStimulus(vecs[1].func, vecs[1].am, vecs[1].bm, vecs[1].ma, vecs[1].mb, vecs[1].mq,
                    vecs[1].expT, vecs[1].expQ, 1'b0, 10, 0);

      $display("[TB] reset during EVAL");
      req_valid = 1'b1;
      req_func  = vecs[2].func;
      req_a_m   = vecs[2].am;
      req_b_m   = vecs[2].bm;
      req_ma    = vecs[2].ma;
      req_mb    = vecs[2].mb;
      req_mq    = vecs[2].mq;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      checkOutput("mid_table_t", 32'(t), 32'(vecs[2].expT));
      @(negedge clk);
      checkOutput("mid_eval_rails", 32'({a_m, a_m_bar, b_m, b_m_bar}), 32'b1010);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      checkOutput("mid_reset_drive", 32'({t, a_m, a_m_bar, b_m, b_m_bar}), 32'd0);
      checkOutput("mid_reset_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("mid_reset_req_ready", 32'(req_ready), 32'd0);
      for (int k = 0; k < PRE_CYCLES - 1; k++) begin
         @(negedge clk);
         checkOutput("mid_init_req_ready", 32'(req_ready), 32'd0);
      end
      @(negedge clk);
      checkOutput("mid_init_done_req_ready", 32'(req_ready), 32'd1);

      $display("[TB] dual-rail error injection");
      applyStimulus(vecs[3].func, vecs[3].am, vecs[3].bm, vecs[3].ma, vecs[3].mb, vecs[3].mq,
                    vecs[3].expT, 1'b1, errExp, 0, 1);
      applyStimulus(vecs[4].func, vecs[4].am, vecs[4].bm, vecs[4].ma, vecs[4].mb, vecs[4].mq,
                    vecs[4].expT, vecs[4].expQ, errExp, 0, 2);
      applyStimulus(vecs[5].func, vecs[5].am, vecs[5].bm, vecs[5].ma, vecs[5].mb, vecs[5].mq,
                    vecs[5].expT, vecs[5].expQ, 1'b0, 0, 0);

      $display("[TB] full func/mask sweep");
      for (int fi = 0; fi < 16; fi++) begin
         for (int ci = 0; ci < 32; ci++) begin
            f    = 4'(fi);
            c    = 5'(ci);
            expQ = f[{c[1] ^ c[3], c[0] ^ c[2]}] ^ c[4];
            applyStimulus(f, c[0], c[1], c[2], c[3], c[4],
                          modelTable(f, c[2], c[3], c[4]), expQ, 1'b0, 0, 0);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
      $finish;
   end

endmodule

// File: doc/lmdpl_nl_seq.md
# lmdpl_nl_seq

Sequencer for one LMDPL non-linear gate instance (the 8-entry masked LUT with dual-rail masked inputs `a_m`/`a_m_bar`, `b_m`/`b_m_bar` and dual-rail output `q_m`/`q_m_bar`). It accepts one masked 2-input Boolean operation per request and generates the 8-bit mask-dependent table `t`. It enforces the precharge → table → evaluate → precharge discipline that keeps the gate glitch-free, then returns the single-rail masked result over a valid/ready handshake. It sits between the masked-datapath control logic and the hard-instantiated gate cells.

## Interface
- `EVAL_CYCLES`, 2: cycles the evaluate phase is held; minimum 1.
- `PRE_CYCLES`, 2: cycles the precharge phase is held, both after each evaluation and after reset; minimum 1.
- `clk`  in  1  Single clock.
- `rst_n`  in  1  Reset; one clock; reset is synchronous and active-low.
- `req_valid`  in  1  Request present.
- `req_ready`  out  1  Request accepted on `req_valid && req_ready` at a rising edge.
- `req_func`  in  4  Truth table of unmasked f: f(a,b) = `req_func[{b,a}]`.
- `req_a_m`, `req_b_m`  in  1 each  Masked input bits (a^ma, b^mb).
- `req_ma`, `req_mb`, `req_mq`  in  1 each  Input masks and fresh output mask.
- `t`  out  8  Gate table.
- `a_m`, `a_m_bar`, `b_m`, `b_m_bar`  out  1 each  Dual-rail gate inputs.
- `q_m`, `q_m_bar`  in  1 each  Dual-rail gate outputs.
- `rsp_valid`  out  1  Result available.
- `rsp_ready`  in  1  Result consumed on `rsp_valid && rsp_ready`.
- `rsp_q_m`  out  1  Masked result, f(a,b)^mq.
- `rsp_err`  out  1  Dual-rail violation flag; see Configuration.

## Operation
- States: INIT, IDLE, TABLE, EVAL, PRE, DONE. The state register and all outputs are registered.
- Precharged drive means `t`=0 and all four input rails = 0.
- INIT: entered on reset. Drive is precharged for PRE_CYCLES, then the block moves to IDLE.
- IDLE: drive is precharged and `req_ready`=1. On accept, the block latches the request fields and moves to TABLE.
- Table generation for i = {ib, ia} in 0..3: v = `req_func[{ib^mb, ia^ma}]` ^ mq, `t[4+i]` = v, `t[i]` = ~v.
- TABLE (1 cycle): `t` is driven and the input rails stay 0.
- EVAL (EVAL_CYCLES cycles): `t` is held. The rails are driven as `a_m`=a, `a_m_bar`=~a, `b_m`=b, `b_m_bar`=~b.
  - On the last EVAL cycle, `q_m` is sampled into `rsp_q_m`.
- PRE (PRE_CYCLES cycles): all rails go to 0 and `t` goes to 0 in the same edge.
- DONE: `rsp_valid`=1 and the drive stays precharged. On `rsp_ready`, `rsp_valid` drops and the block returns to IDLE.
- `req_ready`=1 only in IDLE. At most one operation is in flight.
- Phase counter width is $clog2(max(EVAL_CYCLES, PRE_CYCLES)+1). It is reloaded on every state entry and never wraps.
- `req_*` fields are don't-care outside the accept edge. Latched copies are held until the next accept.

## Timing
- Reset values: `req_ready`=0, `t`=0, all rails 0, `rsp_valid`=0, `rsp_q_m`=0, `rsp_err`=0.
- After reset deasserts, `req_ready` rises after PRE_CYCLES edges.
- With accept at edge E0:
  - TABLE is visible after E0.
  - EVAL is visible after E1 through E(EVAL_CYCLES).
  - PRE follows.
  - `rsp_valid` is first high after E(1+EVAL_CYCLES+PRE_CYCLES); with defaults this is after E5.
- Minimum request-to-request spacing is 3+EVAL_CYCLES+PRE_CYCLES edges.
  - With `rsp_ready` held high, DONE lasts one cycle and `req_ready` returns the next cycle.
- With `rsp_ready` low, DONE holds indefinitely with `rsp_q_m`/`rsp_err` stable.
- `req_valid` arriving while `req_ready`=0 is ignored and not queued.
- Reset mid-operation, in any state: at the next edge the block enters INIT, the drive is precharged immediately, and `rsp_valid` clears. The in-flight result is discarded.
- `t` and the rails never change together except at entry to PRE. At that point all of them fall to 0, so only 1→0 transitions occur.

## Configuration
- `LMDPL_ERR_CHECK_EN` defined:
  - On the last EVAL cycle, `rsp_err` is set if `q_m == q_m_bar`.
  - On the last PRE cycle, `rsp_err` is also set if `q_m | q_m_bar` is 1.
  - The flag clears on accept of the next request.
- Not defined: `rsp_err` is tied to 0 and no comparison logic is built.

## Test plan
- Reset, then release with `req_valid`=1 held: `req_ready` rises after 2 edges; the first accept happens on the next edge and all drives are 0 until then.
- AND operation (func=4'b1000, ma=1, mb=0, mq=1, a_m=0, b_m=1):
  - `t`=8'hB4 in TABLE and EVAL.
  - Rails a=0/1, b=1/0 in EVAL.
  - Gate model returns `q_m`=0, so `rsp_q_m`=0 (unmasked 1), and `rsp_valid` is first high after E5.
- Sweep all 16 func × 32 mask/input combinations against a gate model: `rsp_q_m` ^ mq equals f(a^ma, b^mb) in every case.
- Backpressure: hold `rsp_ready`=0 for 10 cycles in DONE → `rsp_valid`, `rsp_q_m` and `req_ready`=0 are all stable; release → one handshake, then back to IDLE.
- Assert `rst_n`=0 for one cycle during EVAL → the next cycle shows `t`=0, all rails 0 and `rsp_valid`=0, followed by a full INIT before `req_ready`.
- With `LMDPL_ERR_CHECK_EN`:
  - Force `q_m`=`q_m_bar`=1 in EVAL → `rsp_err`=1 in DONE.
  - Force `q_m`=1 during the last PRE cycle → `rsp_err`=1.
  - Without the macro, `rsp_err` stays 0 in both cases.
